// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with any DEPTH >= 2, almost thresholds,
// occupancy count, synchronous flush and selectable first-word-fall-through.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 4,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       w_en,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       r_en,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       write_error,
    output logic                       read_error
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    generate
        if (DEPTH < 2 || DEPTH > 1024) begin : g_bad_depth
            $error("sync_fifo_param: DEPTH must be in 2..1024");
        end
        if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
            $error("sync_fifo_param: AF_THRESH must be in 1..DEPTH");
        end
        if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
            $error("sync_fifo_param: AE_THRESH must be in 0..DEPTH-1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  wr_err_q, wr_err_d;
    logic                  rd_err_q, rd_err_d;
    logic                  wr_acc, rd_acc;

    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));
    assign count        = count_q;
    assign write_error  = wr_err_q;
    assign read_error   = rd_err_q;

    // In FWFT mode the head word is shown directly; data_q keeps the last
    // shown word so the output holds steady once the FIFO runs dry.
    assign data_out = (FWFT != 0 && !empty) ? mem[rd_ptr_q] : data_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;

        wr_acc   = w_en & ~full & ~clr;
        rd_acc   = r_en & ~empty & ~clr;
        wr_err_d = w_en & full & ~clr;
        rd_err_d = r_en & empty & ~clr;

        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (FWFT != 0) begin
            if (!empty) data_d = mem[rd_ptr_q];
        end else if (rd_acc) begin
            data_d = mem[rd_ptr_q];
        end

        // Flush wins over both requests; data_out is deliberately left alone.
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            wr_err_q <= wr_err_d;
            rd_err_q <= rd_err_d;
        end
    end

    // NOTE: storage has no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q] <= data_in;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Single-clock, parametrised FIFO, the successor to the team's dual-clock FIFO. It adds configurable depth (any value ≥ 2, not only powers of two), programmable almost-full/almost-empty thresholds, an occupancy count, a synchronous flush and a selectable first-word-fall-through (FWFT) read mode. It buffers between same-clock producer/consumer blocks and keeps the existing w_en/r_en/full/empty/write_error/read_error signalling, so current UVM monitors reuse unchanged.

Parameters:
DATA_WIDTH, 8, width of data_in/data_out
DEPTH, 16, number of storage entries; legal range 2..1024
AF_THRESH, DEPTH-4, almost_full asserted when count >= AF_THRESH; legal range 1..DEPTH
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH; legal range 0..DEPTH-1
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  input  1  single clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous flush
w_en  input  1  write request
data_in  input  DATA_WIDTH  write data
r_en  input  1  read request
data_out  output  DATA_WIDTH  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  $clog2(DEPTH+1)  current occupancy
write_error  output  1  one-cycle pulse: rejected write
read_error  output  1  one-cycle pulse: rejected read

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr = rd_ptr = count = 0; data_out = 0; write_error = read_error = 0.
  - Flags after reset: empty = 1, full = 0, almost_empty = 1, almost_full = (AF_THRESH == 0, never legal) = 0.
  - Memory contents are not reset.
- Pointers are 0..DEPTH-1 and wrap explicitly from DEPTH-1 to 0, so a non-power-of-two DEPTH works.
- Write acceptance: wr_acc = w_en & ~full & ~clr. On wr_acc, mem[wr_ptr] <= data_in and wr_ptr advances.
- Read acceptance: rd_acc = r_en & ~empty & ~clr. On rd_acc, rd_ptr advances.
- Flag evaluation:
  - full, empty and the almost flags are evaluated on pre-edge state.
  - Writing while full is rejected even if a read occurs in the same cycle.
  - Reading while empty is rejected even if a write occurs in the same cycle.
- count update: next = count + wr_acc - rd_acc. It never exceeds DEPTH and never goes below 0.
- Status outputs: full, empty, almost_full and almost_empty are combinational decodes of the registered count. They change in the cycle after the accepted operation.
- Errors (registered, one-cycle pulses):
  - write_error = 1 in the cycle after w_en & full & ~clr.
  - read_error = 1 in the cycle after r_en & empty & ~clr.
  - Both may assert in the same cycle.
- FWFT = 0 (standard read mode):
  - On rd_acc, data_out <= mem[rd_ptr]; the data is valid the cycle after r_en.
  - data_out holds its value when there is no accepted read, including rejected reads.
- FWFT = 1 (first-word-fall-through mode):
  - data_out = mem[rd_ptr] combinationally while ~empty; the head word is visible with zero latency.
  - r_en acknowledges and pops the head word.
  - When empty, data_out holds the last value presented (register-backed); it is 0 after reset.
  - A word written into an empty FIFO appears on data_out in the cycle after the write, when empty deasserts.
- clr (synchronous, highest priority after rst_n):
  - Pointers and count go to 0; w_en and r_en are ignored that cycle; no error pulses are generated.
  - data_out is unchanged.
- Simultaneous read and write at 0 < count < DEPTH: both are accepted and count is unchanged.
- Simultaneous read and write at count == DEPTH: the read is accepted, the write is rejected with write_error, and count becomes DEPTH-1.
- Simultaneous read and write at count == 0: the write is accepted, the read is rejected with read_error, and count becomes 1.
- Reset asserted mid-burst: all state clears immediately (asynchronously). The first operation after rst_n deasserts is honoured on the next posedge.
- Synthesis elaboration checks must flag illegal parameters: DEPTH < 2, or AF_THRESH / AE_THRESH outside their ranges.

Test Plan:
1. Fill and overflow (DEPTH=16, AF=12, AE=2, FWFT=0): reset, then write 0x00..0x0F.
   - almost_empty deasserts after the 3rd write; almost_full asserts after the 12th write.
   - full = 1 and count = 16 after the 16th write.
   - A 17th write (0xAA) gives write_error high for exactly 1 cycle; count stays 16.
2. Drain and underflow (setup as scenario 1): read 16 times.
   - data_out = 0x00..0x0F, each value one cycle after its r_en.
   - empty = 1 after the last read.
   - An extra read gives a read_error pulse; data_out stays 0x0F.
3. Simultaneous boundaries:
   - At count = 16, assert w_en = r_en = 1 → count = 15, write_error pulse, the oldest word is read out.
   - At count = 0, assert w_en = r_en = 1 (data 0x55) → count = 1, read_error pulse; the next read returns 0x55.
4. Non-power-of-two wrap (DEPTH=5): write 3, read 3, then write 0x10..0x14.
   - Pointers wrap at 4→0; full asserts at count = 5.
   - Reads return 0x10..0x14 in order.
5. FWFT mode (FWFT=1): write 0x3C into the empty FIFO.
   - data_out = 0x3C in the next cycle with no r_en.
   - Asserting r_en pops it: empty = 1, and data_out holds 0x3C.
6. clr and reset mid-operation:
   - With count = 9, assert clr together with w_en and r_en → count = 0, empty = 1, no error pulses.
   - Refill to 6, then pulse rst_n low between clock edges → count = 0 immediately, data_out = 0.
